// File: rtl/alu_arbiter.sv
// Execute-stage controller: round-robin shares one add/sub/and/xor ALU between two
// requesters, registers the result behind a valid/ready channel and keeps the Y86 CC.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [3:0]       r0_ifun,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic             r0_set_cc,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [3:0]       r1_ifun,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [WIDTH-1:0] res_val,
    output logic             res_err,
    output logic [2:0]       cc
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]       state;
    logic             last_grant;
    logic             can_accept;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             sel;
    logic [3:0]       sel_ifun;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] y;
    logic             illegal;
    logic             of_flag;
    logic             cc_write;

    always_comb begin
        can_accept = (state == IDLE) || res_ready;
        // On a tie the port that did not win last time is granted.
        grant0     = r0_valid && (!r1_valid || last_grant);
        grant1     = r1_valid && (!r0_valid || !last_grant);
        r0_ready   = can_accept && grant0;
        r1_ready   = can_accept && grant1;
        accept     = r0_ready || r1_ready;
        sel        = grant1;
        sel_ifun   = sel ? r1_ifun : r0_ifun;
        sel_a      = sel ? r1_a : r0_a;
        sel_b      = sel ? r1_b : r0_b;
        illegal    = (sel_ifun > 4'd3);
    end

    always_comb begin
        y       = '0;
        of_flag = 1'b0;
        case (sel_ifun)
            4'd0: begin
                y       = sel_b + sel_a;
                of_flag = (sel_a[WIDTH-1] == sel_b[WIDTH-1]) && (y[WIDTH-1] != sel_b[WIDTH-1]);
            end
            4'd1: begin
                y       = sel_b - sel_a;
                of_flag = (sel_a[WIDTH-1] != sel_b[WIDTH-1]) && (y[WIDTH-1] != sel_b[WIDTH-1]);
            end
            4'd2:    y = sel_b & sel_a;
            4'd3:    y = sel_b ^ sel_a;
            default: y = '0;
        endcase
        cc_write = accept && !sel && r0_set_cc && !illegal;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            res_val    <= '0;
            res_id     <= 1'b0;
            res_err    <= 1'b0;
            cc         <= 3'b100;
        end else begin
            if (accept) begin
                state      <= HOLD;
                last_grant <= sel;
                res_val    <= y;
                res_id     <= sel;
                res_err    <= illegal;
            end else if (state == HOLD && res_ready) begin
                state <= IDLE;
            end
            if (cc_write) begin
                cc <= {(y == '0), y[WIDTH-1], of_flag};
            end
        end
    end

    always_comb begin
        res_valid = (state == HOLD);
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: table of single operations plus hand-written
// sequences for contention, output stall, reset in HOLD and result drain.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0_valid, r0_ready, r0_set_cc;
    logic [3:0]  r0_ifun;
    logic [31:0] r0_a, r0_b;
    logic        r1_valid, r1_ready;
    logic [3:0]  r1_ifun;
    logic [31:0] r1_a, r1_b;
    logic        res_valid, res_ready, res_id, res_err;
    logic [31:0] res_val;
    logic [2:0]  cc;

    int unsigned total  = 0;
    int unsigned passed = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_ifun(r0_ifun),
        .r0_a(r0_a), .r0_b(r0_b), .r0_set_cc(r0_set_cc),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_ifun(r1_ifun),
        .r1_a(r1_a), .r1_b(r1_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_val(res_val), .res_err(res_err), .cc(cc)
    );

    typedef struct {
        logic        port;
        logic [3:0]  ifun;
        logic [31:0] a;
        logic [31:0] b;
        logic        set_cc;
        logic [31:0] exp_val;
        logic        exp_err;
        logic [2:0]  exp_cc;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic idle_inputs();
        r0_valid = 0; r0_set_cc = 0; r0_ifun = 0; r0_a = 0; r0_b = 0;
        r1_valid = 0; r1_ifun = 0; r1_a = 0; r1_b = 0;
    endtask

    initial begin
        // port, ifun, a, b, set_cc, expected value, err, cc
        vecs[0] = '{1'b0, 4'd0, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 32'h8000_0000, 1'b0, 3'b011};
        vecs[1] = '{1'b0, 4'd1, 32'd5,         32'd5,         1'b1, 32'h0000_0000, 1'b0, 3'b100};
        vecs[2] = '{1'b1, 4'd1, 32'd6,         32'd5,         1'b0, 32'hFFFF_FFFF, 1'b0, 3'b100};
        vecs[3] = '{1'b0, 4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'hF000_F000, 1'b0, 3'b010};
        vecs[4] = '{1'b0, 4'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'h0FF0_0FF0, 1'b0, 3'b000};
        vecs[5] = '{1'b0, 4'd7, 32'h1234_5678, 32'h0000_0001, 1'b1, 32'h0000_0000, 1'b1, 3'b000};
        vecs[6] = '{1'b0, 4'd0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b0, 3'b000};
        vecs[7] = '{1'b0, 4'd1, 32'h0000_0001, 32'h8000_0000, 1'b1, 32'h7FFF_FFFF, 1'b0, 3'b001};
        vecs[8] = '{1'b1, 4'd0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 3'b001};
        vecs[9] = '{1'b1, 4'd4, 32'h0000_0003, 32'h0000_0004, 1'b0, 32'h0000_0000, 1'b1, 3'b001};

        idle_inputs();
        res_ready = 1;
        reset = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        #1;
        check("reset_cc", {29'd0, cc}, 32'h4);
        check("reset_res_valid", {31'd0, res_valid}, 32'd0);
        check("reset_res_val", res_val, 32'd0);
        check("reset_res_id", {31'd0, res_id}, 32'd0);
        check("reset_res_err", {31'd0, res_err}, 32'd0);

        // Single-port operations, issued back to back with res_ready held high.
        for (int i = 0; i < 10; i++) begin
            if (i != 0) @(negedge clk);
            idle_inputs();
            if (vecs[i].port == 1'b0) begin
                r0_valid = 1; r0_ifun = vecs[i].ifun; r0_a = vecs[i].a;
                r0_b = vecs[i].b; r0_set_cc = vecs[i].set_cc;
            end else begin
                r1_valid = 1; r1_ifun = vecs[i].ifun; r1_a = vecs[i].a; r1_b = vecs[i].b;
            end
            #1;
            check($sformatf("v%0d_r0_ready", i), {31'd0, r0_ready}, {31'd0, ~vecs[i].port});
            check($sformatf("v%0d_r1_ready", i), {31'd0, r1_ready}, {31'd0, vecs[i].port});
            @(posedge clk); #1;
            check($sformatf("v%0d_res_valid", i), {31'd0, res_valid}, 32'd1);
            check($sformatf("v%0d_res_val", i), res_val, vecs[i].exp_val);
            check($sformatf("v%0d_res_id", i), {31'd0, res_id}, {31'd0, vecs[i].port});
            check($sformatf("v%0d_res_err", i), {31'd0, res_err}, {31'd0, vecs[i].exp_err});
            check($sformatf("v%0d_cc", i), {29'd0, cc}, {29'd0, vecs[i].exp_cc});
        end

        // Sustained contention: last grant was port 1, so port 0 leads.
        @(negedge clk);
        idle_inputs();
        r0_valid = 1; r0_ifun = 0; r0_a = 32'h1; r0_b = 32'h10;
        r1_valid = 1; r1_ifun = 0; r1_a = 32'h2; r1_b = 32'h20;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("rr%0d_res_id", i), {31'd0, res_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
            check($sformatf("rr%0d_res_val", i), res_val, (i % 2 == 0) ? 32'h11 : 32'h22);
            check($sformatf("rr%0d_res_valid", i), {31'd0, res_valid}, 32'd1);
        end

        // Output stall with both ports still requesting.
        @(negedge clk);
        res_ready = 0;
        #1;
        check("stall_r0_ready", {31'd0, r0_ready}, 32'd0);
        check("stall_r1_ready", {31'd0, r1_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("stall%0d_res_id", i), {31'd0, res_id}, 32'd1);
            check($sformatf("stall%0d_res_val", i), res_val, 32'h22);
            check($sformatf("stall%0d_res_valid", i), {31'd0, res_valid}, 32'd1);
            check($sformatf("stall%0d_readys", i), {30'd0, r1_ready, r0_ready}, 32'd0);
        end
        @(negedge clk);
        res_ready = 1;
        #1;
        check("release_r0_ready", {31'd0, r0_ready}, 32'd1);
        check("release_r1_ready", {31'd0, r1_ready}, 32'd0);
        @(posedge clk); #1;
        check("release0_res_id", {31'd0, res_id}, 32'd0);
        check("release0_res_val", res_val, 32'h11);
        @(posedge clk); #1;
        check("release1_res_id", {31'd0, res_id}, 32'd1);
        check("release1_res_val", res_val, 32'h22);

        // Reset while holding a result, with requests present during reset.
        @(negedge clk);
        res_ready = 0;
        reset = 1;
        @(posedge clk); #1;
        check("rst_hold_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_hold_cc", {29'd0, cc}, 32'h4);
        check("rst_hold_res_val", res_val, 32'd0);
        @(negedge clk);
        res_ready = 1;
        @(posedge clk); #1;
        check("rst_no_accept", {31'd0, res_valid}, 32'd0);
        @(negedge clk);
        reset = 0;
        idle_inputs();

        // Drain: result consumed with no follow-up request, held value kept.
        r0_valid = 1; r0_ifun = 0; r0_a = 32'd3; r0_b = 32'd4;
        @(posedge clk); #1;
        check("drain_res_val", res_val, 32'd7);
        check("drain_res_valid", {31'd0, res_valid}, 32'd1);
        @(negedge clk);
        idle_inputs();
        @(posedge clk); #1;
        check("drain_idle_valid", {31'd0, res_valid}, 32'd0);
        check("drain_keep_val", res_val, 32'd7);
        check("drain_keep_id", {31'd0, res_id}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
